// File: rtl/gearbox_lock_ctrl_pkg.sv
// Shared definitions for the 64b/66b block-lock controller: state set,
// sync-header constants and parameter defaults.
package gearbox_lock_ctrl_pkg;

    localparam int SH_CNT_MAX_DEF  = 64;
    localparam int INVALID_MAX_DEF = 16;
    localparam int SLIP_WAIT_DEF   = 4;

    localparam logic [1:0] SH_SYNC_DATA = 2'b01;
    localparam logic [1:0] SH_SYNC_CTRL = 2'b10;

    typedef enum logic [2:0] {
        ST_LOCK_INIT = 3'd0,
        ST_RESET_CNT = 3'd1,
        ST_TEST_SH   = 3'd2,
        ST_GOOD_WIN  = 3'd3,
        ST_SLIP      = 3'd4,
        ST_SLIP_WAIT = 3'd5
    } lock_state_e;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_SYNC_DATA) || (sh == SH_SYNC_CTRL);
    endfunction

endpackage

// File: rtl/gearbox_lock_ctrl_if.sv
// Gearbox-side signal bundle: header stream in, slip request and lock status out.
interface gearbox_lock_ctrl_if;
    logic        enable;
    logic        sh_valid;
    logic [1:0]  sh;
    logic        slip;
    logic        block_lock;
    logic [15:0] slip_cnt;
    logic        lock_loss;

    modport master (
        output enable, sh_valid, sh,
        input  slip, block_lock, slip_cnt, lock_loss
    );

    modport slave (
        input  enable, sh_valid, sh,
        output slip, block_lock, slip_cnt, lock_loss
    );
endinterface

// File: rtl/lock_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second clock edge after rst_n rises.
module lock_rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);
    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign rst_sync_n = sync_reg[1];
endmodule

// File: rtl/gearbox_lock_ctrl.sv
// Block-lock FSM for a 66-bit gearbox: hunts for header alignment by slipping,
// declares lock after a clean window and drops it on too many bad headers.
module gearbox_lock_ctrl
    import gearbox_lock_ctrl_pkg::*;
#(
    parameter int SH_CNT_MAX  = SH_CNT_MAX_DEF,
    parameter int INVALID_MAX = INVALID_MAX_DEF,
    parameter int SLIP_WAIT   = SLIP_WAIT_DEF
) (
    input logic                clk,
    input logic                rst_n,
    gearbox_lock_ctrl_if.slave bus
);
    localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(INVALID_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [2:0] S_LOCK_INIT = 3'(ST_LOCK_INIT);
    localparam logic [2:0] S_RESET_CNT = 3'(ST_RESET_CNT);
    localparam logic [2:0] S_TEST_SH   = 3'(ST_TEST_SH);
    localparam logic [2:0] S_GOOD_WIN  = 3'(ST_GOOD_WIN);
    localparam logic [2:0] S_SLIP      = 3'(ST_SLIP);
    localparam logic [2:0] S_SLIP_WAIT = 3'(ST_SLIP_WAIT);

    logic rst_sync_n;

    lock_rst_sync u_rst_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (rst_sync_n)
    );

    logic [2:0]        state_reg, state_next;
    logic [SH_W-1:0]   sh_cnt_reg, sh_cnt_next;
    logic [INV_W-1:0]  invalid_cnt_reg, invalid_cnt_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              block_lock_reg, block_lock_next;
    logic              slip_reg, slip_next;
    logic              lock_loss_reg, lock_loss_next;
    logic [15:0]       slip_cnt_reg, slip_cnt_next;

    logic              word_bad;
    logic [SH_W-1:0]   sh_cnt_inc;
    logic [INV_W-1:0]  invalid_cnt_inc;
    logic [WAIT_W-1:0] wait_cnt_inc;

    assign word_bad        = !sh_is_valid(bus.sh);
    assign sh_cnt_inc      = sh_cnt_reg + 1'b1;
    assign invalid_cnt_inc = invalid_cnt_reg + INV_W'(word_bad);
    assign wait_cnt_inc    = wait_cnt_reg + 1'b1;

    always_comb begin
        state_next       = state_reg;
        sh_cnt_next      = sh_cnt_reg;
        invalid_cnt_next = invalid_cnt_reg;
        wait_cnt_next    = wait_cnt_reg;
        block_lock_next  = block_lock_reg;
        slip_next        = 1'b0;
        lock_loss_next   = 1'b0;
        slip_cnt_next    = slip_cnt_reg;

        if (!bus.enable) begin
            state_next      = S_LOCK_INIT;
            block_lock_next = 1'b0;
            lock_loss_next  = block_lock_reg;
        end else begin
            case (state_reg)
                S_LOCK_INIT: state_next = S_RESET_CNT;
                S_RESET_CNT: begin
                    sh_cnt_next      = '0;
                    invalid_cnt_next = '0;
                    state_next       = S_TEST_SH;
                end
                S_TEST_SH: begin
                    if (bus.sh_valid) begin
                        sh_cnt_next      = sh_cnt_inc;
                        invalid_cnt_next = invalid_cnt_inc;
                        // Slip is checked first so it wins when both limits land on one word.
                        if (word_bad && (invalid_cnt_inc >= INV_W'(INVALID_MAX) || !block_lock_reg)) begin
                            state_next      = S_SLIP;
                            slip_next       = 1'b1;
                            block_lock_next = 1'b0;
                            lock_loss_next  = block_lock_reg;
                            if (slip_cnt_reg != 16'hFFFF) begin
                                slip_cnt_next = slip_cnt_reg + 16'd1;
                            end
                        end else if (sh_cnt_inc == SH_W'(SH_CNT_MAX)) begin
                            if (invalid_cnt_inc == '0) begin
                                state_next      = S_GOOD_WIN;
                                block_lock_next = 1'b1;
                            end else begin
                                state_next = S_RESET_CNT;
                            end
                        end
                    end
                end
                S_GOOD_WIN: begin
                    block_lock_next = 1'b1;
                    state_next      = S_RESET_CNT;
                end
                S_SLIP: begin
                    wait_cnt_next = '0;
                    state_next    = S_SLIP_WAIT;
                end
                S_SLIP_WAIT: begin
                    // Headers are meaningless while the gearbox realigns; only count words.
                    if (bus.sh_valid) begin
                        wait_cnt_next = wait_cnt_inc;
                        if (wait_cnt_inc == WAIT_W'(SLIP_WAIT)) begin
                            state_next = S_RESET_CNT;
                        end
                    end
                end
                default: state_next = S_LOCK_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_reg       <= S_LOCK_INIT;
            sh_cnt_reg      <= '0;
            invalid_cnt_reg <= '0;
            wait_cnt_reg    <= '0;
            block_lock_reg  <= 1'b0;
            slip_reg        <= 1'b0;
            lock_loss_reg   <= 1'b0;
            slip_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            sh_cnt_reg      <= sh_cnt_next;
            invalid_cnt_reg <= invalid_cnt_next;
            wait_cnt_reg    <= wait_cnt_next;
            block_lock_reg  <= block_lock_next;
            slip_reg        <= slip_next;
            lock_loss_reg   <= lock_loss_next;
            slip_cnt_reg    <= slip_cnt_next;
        end
    end

    assign bus.slip       = slip_reg;
    assign bus.block_lock = block_lock_reg;
    assign bus.lock_loss  = lock_loss_reg;
    assign bus.slip_cnt   = slip_cnt_reg;

endmodule

// File: doc/gearbox_lock_ctrl.md
GEARBOX_LOCK_CTRL -- requirements
Module: gearbox_lock_ctrl

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64: valid words per test window.
REQ-002 SHALL have parameter INVALID_MAX, default 16: invalid headers per window that force a slip.
REQ-003 SHALL have parameter SLIP_WAIT, default 4: valid words ignored after each slip while the gearbox settles.
REQ-004 SHALL have port clk, input, 1: sole clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1: 0 holds the FSM in LOCK_INIT.
REQ-007 SHALL have port sh_valid, input, 1: gearbox 66-bit word valid.
REQ-008 SHALL have port sh, input, 2: sync header, i.e. bits [1:0] of the gearbox word.
REQ-009 SHALL have port slip, output, 1: one-cycle pulse telling the gearbox to shift one bit position.
REQ-010 SHALL have port block_lock, output, 1: word alignment acquired.
REQ-011 SHALL have port slip_cnt, output, 16: saturating count of slips since reset.
REQ-012 SHALL have port lock_loss, output, 1: one-cycle pulse when block_lock falls.

Function
REQ-013 A header SHALL be valid iff sh is 2'b01 or 2'b10; 00 and 11 are invalid.
REQ-014 Words SHALL be evaluated only in cycles with sh_valid=1; other cycles leave counters and state unchanged.
REQ-015 States SHALL be LOCK_INIT, RESET_CNT, TEST_SH, GOOD_WIN, SLIP, SLIP_WAIT.
REQ-016 LOCK_INIT: block_lock=0; next RESET_CNT when enable=1.
REQ-017 RESET_CNT: clear sh_cnt and invalid_cnt; next TEST_SH in one cycle.
REQ-018 TEST_SH, on sh_valid: sh_cnt+1; on invalid header also invalid_cnt+1.
REQ-019 In TEST_SH, if invalid_cnt reaches INVALID_MAX, or block_lock=0 and any invalid header occurs, next state SHALL be SLIP.
REQ-020 In TEST_SH, if sh_cnt reaches SH_CNT_MAX with invalid_cnt=0, next state SHALL be GOOD_WIN; block_lock goes 1.
REQ-021 In TEST_SH, if sh_cnt reaches SH_CNT_MAX with 0<invalid_cnt<INVALID_MAX and block_lock=1, next state SHALL be RESET_CNT; lock is held.
REQ-022 GOOD_WIN SHALL set block_lock=1 and go to RESET_CNT the next cycle.
REQ-023 SLIP SHALL assert slip for exactly one cycle; block_lock goes 0, with a lock_loss pulse in the same cycle if it was 1; slip_cnt+1 (saturating at 16'hFFFF); next SLIP_WAIT.
REQ-024 SLIP_WAIT SHALL count SLIP_WAIT valid words, then go to RESET_CNT; headers in this state are ignored.
REQ-025 If the INVALID_MAX hit and the SH_CNT_MAX hit fall on the same word, SLIP SHALL take priority.
REQ-026 Two slip pulses SHALL be separated by at least SLIP_WAIT+2 cycles.
REQ-027 enable=0 SHALL force LOCK_INIT in the next cycle from any state; a slip in flight completes its single cycle only.
REQ-028 Outputs SHALL be registered; slip asserts one cycle after the triggering sh_valid word.
REQ-029 Counter widths SHALL be $clog2(max+1); all comparisons are unsigned.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately set LOCK_INIT, block_lock=0, slip=0, lock_loss=0, slip_cnt=0, and clear all counters.
REQ-031 Deassertion SHALL be synchronized internally; the FSM leaves LOCK_INIT no earlier than the second clk after release.
REQ-032 Reset mid-SLIP_WAIT SHALL discard the wait and produce no slip pulse.

Structure
REQ-033 A shared package SHALL hold the state enum, the SH_SYNC_DATA=2'b01 and SH_SYNC_CTRL=2'b10 constants, and the parameter defaults.
REQ-034 A single sub-module, lock_rst_sync (2-flop async-assert/sync-release synchronizer), SHALL be used; the FSM and counters stay in the top.

Verification
REQ-035 Aligned stream: 64 valid headers after reset -> block_lock=1 on the cycle after the 64th word; slip never asserted.
REQ-036 Misaligned stream with all sh=11 -> slip pulses every SLIP_WAIT+2+ cycles; slip_cnt increments on each pulse; block_lock stays 0.
REQ-037 When locked, 15 invalid headers in a 64-word window -> lock held and counters reset; 16 invalid headers -> slip pulse, block_lock=0, and lock_loss pulses once.
REQ-038 sh_valid toggled 1-of-3 cycles on an aligned stream -> lock after exactly 64 valid words, not 64 cycles.
REQ-039 rst_n pulsed low during SLIP_WAIT -> outputs cleared asynchronously, no slip, re-lock after 64 good words.
REQ-040 enable dropped while locked -> LOCK_INIT next cycle, block_lock=0, lock_loss=1 for one cycle.
